rr_mux_arbiter: RTL and testbench
=================================

// Module: rr_mux_arbiter
// PURPOSE
//  Round-robin scheduler that shares one W-bit output channel among four
//  requesters by driving the select of a 4:1 data mux.
//  Each requester offers data with req/ack. The granted source streams beats
//  to a valid/ready sink.
//  The grant is held for up to QUANTUM beats, then rotated, so no requester
//  starves. Sits between the lab peripherals and any shared sink (LED/seg/UART).
// PARAMETERS
//  W        8  width of each data input and out_data
//  QUANTUM  4  max beats per grant before forced rotation (1..255)
// PORTS
//  clk        in   1    system clock, rising edge
//  rst        in   1    asynchronous, active-high reset
//  req        in   4    req[i]=1: requester i has a beat on data_i
//  data_0..3  in   W    requester payloads
//  ack        out  4    ack[i]=1: beat from i accepted this cycle
//  out_valid  out  1    out_data holds a valid beat
//  out_ready  in   1    sink accepts a beat when out_valid & out_ready
//  out_data   out  W    mux(data_0..3, sel); comb. from sel
//  sel        out  2    current mux select (registered)
//  grant      out  4    one-hot grant (registered); 0 in IDLE
// BEHAVIOUR
//  Clock and reset: one clock, clk; reset rst is asynchronous, active-high.
//  Reset values:
//   - state=IDLE, sel=0, grant=0, ptr=0 (requester 0 highest priority), cnt=0.
//   - out_valid=0, ack=0, out_data=data_0.
//  States: IDLE (no grant) and BUSY (grant[sel]=1).
//  Arbitration (comb.):
//   - Scan req starting at ptr, in order ptr, ptr+1, ... mod 4.
//   - The first set bit is the winner.
//  IDLE: if |req, next cycle BUSY with sel=winner, grant=1<<winner, cnt=0.
//   Latency is 1 cycle from req rise to out_valid.
//  BUSY:
//   - out_valid = req[sel].
//   - ack = grant & {4{req[sel] & out_ready}}. At most one ack bit is set.
//   - xfer = out_valid & out_ready. On xfer, cnt increments (8-bit counter).
//  Release condition, evaluated in BUSY:
//   (a) xfer and cnt+1 == QUANTUM, or
//   (b) req[sel]==0 (requester withdrew or finished).
//  On release:
//   - ptr <= sel+1 (mod 4, wraps 3 -> 0) and cnt <= 0.
//   - Re-arbitrate in the same cycle using the new ptr. If any req, go straight
//     to BUSY with the new winner, with no bubble; else go to IDLE and grant <= 0.
//   - A released requester regains the grant immediately only if it is the
//     sole requester.
//  Simultaneous xfer and release in one cycle: the beat is acked and counted,
//   and the new grant takes effect next cycle.
//  out_ready low in BUSY: hold sel/grant/cnt; no ack; no rotation (no timeout).
//  Requester contract: hold req and data stable until ack.
//  ptr updates only on release, never in IDLE.
//  rst mid-stream: all state returns to reset values immediately; an in-flight
//   beat is dropped and no ack is issued.
// TESTING
//  1 Reset: rst=1 with req=4'hF -> grant=0, out_valid=0, ack=0, sel=0.
//  2 Single source: req=4'b0100, data_2=8'hA5, out_ready=1 -> cycle+1: sel=2,
//    out_valid=1, out_data=A5, ack=4'b0100. After 4 beats, re-grant to 2
//    with no bubble.
//  3 Rotation: req=4'hF held, out_ready=1, QUANTUM=4 -> grants 0,1,2,3,0.
//    Each grant lasts 4 acked beats, with no idle cycles.
//  4 Withdrawal: grant=1, req[1] drops after 2 beats with req[3]=1 ->
//    next cycle sel=3. ptr was 2, so 3 wins.
//  5 Backpressure: out_ready=0 for 10 cycles in BUSY -> ack=0, sel stable,
//    cnt frozen. Release QUANTUM beats after out_ready returns.
//  6 Async reset mid-BUSY (sel=3, cnt=2): rst pulsed between edges ->
//    outputs reset immediately. After release, req=4'hF -> grant 0 first.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin scheduler that shares one W-bit valid/ready output
// channel among four req/ack requesters by driving the select of a 4:1 data mux.
// A grant lasts up to QUANTUM accepted beats or until its requester drops req.
// When a grant is released, arbitration restarts just past the released
// requester in the same cycle, so there is no bubble.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req[3:0]   req[i]=1: requester i offers a beat on data_i
//   data_0..3  requester payloads (W bits each)
//   ack[3:0]   ack[i]=1: beat from requester i accepted this cycle
//   out_valid  out_data holds a valid beat
//   out_ready  sink accepts a beat when out_valid & out_ready
//   out_data   mux(data_0..3, sel), combinational from sel
//   sel[1:0]   current mux select (registered)
//   grant[3:0] one-hot grant (registered), 0 when idle
module rr_mux_arbiter #(
  parameter int unsigned W       = 8,
  parameter int unsigned QUANTUM = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [W-1:0] data_0,
  input  logic [W-1:0] data_1,
  input  logic [W-1:0] data_2,
  input  logic [W-1:0] data_3,
  output logic [3:0]   ack,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   sel,
  output logic [3:0]   grant
);

  typedef enum logic {StIdle, StBusy} state_e;

  // cnt+1 == QUANTUM, expressed against the current count
  localparam logic [7:0] QuantumLast = 8'(QUANTUM - 1);

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;

  logic [1:0] scan_base;
  logic [1:0] scan_idx;
  logic [1:0] winner;
  logic       found;
  logic       xfer;
  logic       release_grant;

  // In BUSY the scan is only used on release, where the new pointer is sel+1;
  // this puts the released requester last so it only wins when it is alone.
  always_comb begin
    scan_base = (state_q == StBusy) ? sel_q + 2'd1 : ptr_q;
    scan_idx  = scan_base;
    winner    = scan_base;
    found     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      scan_idx = scan_base + 2'(i);
      if (!found && req[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    out_valid     = 1'b0;
    ack           = 4'b0000;
    xfer          = 1'b0;
    release_grant = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StBusy;
          sel_d   = winner;
          grant_d = 4'b0001 << winner;
          cnt_d   = 8'd0;
        end
      end
      StBusy: begin
        out_valid     = req[sel_q];
        ack           = grant_q & {4{req[sel_q] & out_ready}};
        xfer          = out_valid & out_ready;
        release_grant = (xfer && (cnt_q == QuantumLast)) || !req[sel_q];
        if (release_grant) begin
          ptr_d = sel_q + 2'd1;
          cnt_d = 8'd0;
          if (found) begin
            sel_d   = winner;
            grant_d = 4'b0001 << winner;
          end else begin
            state_d = StIdle;
            grant_d = 4'b0000;
          end
        end else if (xfer) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= 2'd0;
      grant_q <= 4'b0000;
      ptr_q   <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    unique case (sel_q)
      2'd0:    out_data = data_0;
      2'd1:    out_data = data_1;
      2'd2:    out_data = data_2;
      default: out_data = data_3;
    endcase
  end

  assign sel   = sel_q;
  assign grant = grant_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: stimulus pushes the expected
// {sel, data} of every beat into a queue; a monitor pops and compares each
// beat the DUT delivers (out_valid & out_ready) on the falling edge.
module tb_rr_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'hF;
  logic [7:0] data_0 = 8'h11;
  logic [7:0] data_1 = 8'h22;
  logic [7:0] data_2 = 8'hA5;
  logic [7:0] data_3 = 8'h4E;
  logic [3:0] ack;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic [1:0] sel;
  logic [3:0] grant;

  int total = 0;
  int bad   = 0;

  logic [9:0] exp_q[$];

  rr_mux_arbiter #(
    .W      (8),
    .QUANTUM(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data_0   (data_0),
    .data_1   (data_1),
    .data_2   (data_2),
    .data_3   (data_3),
    .ack      (ack),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .sel      (sel),
    .grant    (grant)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] src_data(input logic [1:0] s);
    case (s)
      2'd0:    return 8'h11;
      2'd1:    return 8'h22;
      2'd2:    return 8'hA5;
      default: return 8'h4E;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_beats(input logic [1:0] s, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({s, src_data(s)});
  endtask

  // Wait for n delivered beats, counting cycles with out_valid low on the way.
  task automatic run_beats(input int n, input int exp_idle, input string name);
    int got  = 0;
    int idle = 0;
    int cyc  = 0;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!out_valid) idle++;
      if (out_valid && out_ready) got++;
    end
    chk({name, "_beats"}, got, n);
    chk({name, "_idle"}, idle, exp_idle);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 4'h0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every delivered beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {30'd0, sel}, 32'hFFFF_FFFF);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("beat_sel", {30'd0, sel}, {30'd0, e[9:8]});
        chk("beat_data", {24'd0, out_data}, {24'd0, e[7:0]});
        chk("beat_ack", {28'd0, ack}, {28'd0, 4'b0001 << e[9:8]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset held with every requester asking
    repeat (3) @(negedge clk);
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ack", {28'd0, ack}, 32'd0);
    chk("rst_sel", {30'd0, sel}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'h11);
    req = 4'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 2: single source, re-granted with no bubble after its quantum
    do_reset();
    push_beats(2'd2, 8);
    req = 4'b0100;
    run_beats(8, 1, "single");
    req = 4'h0;

    // 3: full rotation 0,1,2,3,0 with all requesters active
    do_reset();
    push_beats(2'd0, 4);
    push_beats(2'd1, 4);
    push_beats(2'd2, 4);
    push_beats(2'd3, 4);
    push_beats(2'd0, 4);
    req = 4'hF;
    run_beats(20, 1, "rotate");
    req = 4'h0;

    // 4: requester 1 withdraws after two beats, requester 3 takes over
    do_reset();
    push_beats(2'd1, 2);
    push_beats(2'd3, 3);
    req = 4'b1010;
    run_beats(2, 1, "withdraw_a");
    req = 4'b1000;
    run_beats(3, 1, "withdraw_b");
    req = 4'h0;

    // 5: backpressure mid-grant freezes count, then quantum completes
    do_reset();
    push_beats(2'd0, 4);
    push_beats(2'd1, 4);
    req = 4'b0011;
    run_beats(2, 1, "bp_a");
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_ack", {28'd0, ack}, 32'd0);
      chk("bp_sel", {30'd0, sel}, 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    run_beats(6, 0, "bp_b");
    req = 4'h0;

    // 6: asynchronous reset between edges while busy on requester 3
    do_reset();
    push_beats(2'd3, 2);
    req = 4'b1000;
    run_beats(2, 1, "arst_a");
    #2;
    rst = 1'b1;
    #1;
    chk("arst_grant", {28'd0, grant}, 32'd0);
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_ack", {28'd0, ack}, 32'd0);
    chk("arst_sel", {30'd0, sel}, 32'd0);
    rst = 1'b0;
    req = 4'hF;
    push_beats(2'd0, 4);
    run_beats(4, 1, "arst_b");
    req = 4'h0;

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
